// File: rtl/uart_message_sender.sv
// Streams a DEPTH-byte message buffer into uart_tx via its ready/clock-enable
// handshake, one-shot or periodically with a programmable inter-message gap.
module uart_message_sender #(
  parameter int DEPTH       = 16,
  parameter int GAP_WIDTH   = 24,
  parameter int DEFAULT_GAP = 12000000,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [7:0]           wr_data,
  input  logic [AW:0]          msg_len,
  input  logic [GAP_WIDTH-1:0] gap_cycles,
  input  logic                 repeat_mode,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 uart_ready,
  output logic [7:0]           uart_data,
  output logic                 uart_clock_enable,
  output logic                 busy,
  output logic                 msg_done
);

  typedef enum logic [2:0] {IDLE, FETCH, OFFER, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  state_t               state;
  logic [7:0]           mem [DEPTH];
  logic [AW-1:0]        idx;
  logic [AW:0]          len_q;
  logic [GAP_WIDTH-1:0] gap_q, gap_cnt;
  logic [1:0]           wb_cnt;
  logic                 restrobed, abort_q;
  logic                 last_byte;

  assign last_byte = ({1'b0, idx} == len_q - LEN_ONE);

  // Host writes only land while no byte is being fetched or handed off.
  always_ff @(posedge clock)
    if (wr_en && (state == IDLE || state == GAP)) mem[wr_addr] <= wr_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      uart_data         <= '0;
      uart_clock_enable <= 1'b0;
      busy              <= 1'b0;
      msg_done          <= 1'b0;
      idx               <= '0;
      len_q             <= '0;
      gap_q             <= GAP_WIDTH'(DEFAULT_GAP);
      gap_cnt           <= '0;
      wb_cnt            <= '0;
      restrobed         <= 1'b0;
      abort_q           <= 1'b0;
    end else begin
      uart_clock_enable <= 1'b0;
      msg_done          <= 1'b0;
      case (state)
        IDLE: begin
          abort_q <= 1'b0;
          if (start && !abort && msg_len != '0) begin
            len_q <= msg_len;
            idx   <= '0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH:
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            uart_data <= mem[idx];
            state     <= OFFER;
          end
        OFFER:
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (uart_ready) begin
            uart_clock_enable <= 1'b1;
            wb_cnt            <= '0;
            restrobed         <= 1'b0;
            state             <= WAIT_BUSY;
          end
        WAIT_BUSY: begin
          if (abort) abort_q <= 1'b1;
          // A strobe uart_tx missed gets exactly one retry after 4 ready cycles.
          if (!uart_ready) state <= WAIT_DONE;
          else if (wb_cnt == 2'd3 && !restrobed) begin
            uart_clock_enable <= 1'b1;
            restrobed         <= 1'b1;
          end else if (wb_cnt != 2'd3) wb_cnt <= wb_cnt + 2'd1;
        end
        WAIT_DONE:
          if (uart_ready) begin
            if (abort_q || abort) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else if (last_byte) begin
              msg_done <= 1'b1;
              if (repeat_mode) begin
                gap_q   <= gap_cycles;
                gap_cnt <= '0;
                state   <= GAP;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              idx   <= idx + AW'(1);
              state <= FETCH;
            end
          end else if (abort) abort_q <= 1'b1;
        GAP:
          // Counting up to gap_q spends the same gap_q+1 cycles as a down-count.
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (gap_cnt == gap_q) begin
            if (msg_len == '0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              len_q <= msg_len;
              idx   <= '0;
              state <= FETCH;
            end
          end else gap_cnt <= gap_cnt + GAP_WIDTH'(1);
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_message_sender.sv
// Directed-plus-random bench for uart_message_sender with a behavioural uart_tx
// model and a strobe scoreboard compared against a byte-array message model.
module tb_uart_message_sender;
  localparam int DEPTH = 16;
  localparam int GW    = 24;
  localparam int AW    = 4;

  logic          clock = 1'b0, reset = 1'b1;
  logic          wr_en = 1'b0, repeat_mode = 1'b0, start = 1'b0, abort = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic [AW:0]   msg_len = '0;
  logic [GW-1:0] gap_cycles = '0;
  logic          uart_ready = 1'b1;
  logic [7:0]    uart_data;
  logic          uart_clock_enable, busy, msg_done;

  int checks = 0, failures = 0, cyc = 0;
  logic [7:0] mem_model [DEPTH];
  logic [7:0] hello [7];
  logic [7:0] sq[$];
  int         sc[$], dc[$];
  int         byte_cyc = 100;
  bit         stub_mode = 1'b0, stub_done = 1'b0;
  int         hold_cnt = 0, busy_cnt = 0;

  uart_message_sender #(.DEPTH(DEPTH), .GAP_WIDTH(GW), .DEFAULT_GAP(1000)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .gap_cycles(gap_cycles), .repeat_mode(repeat_mode),
    .start(start), .abort(abort), .uart_ready(uart_ready), .uart_data(uart_data),
    .uart_clock_enable(uart_clock_enable), .busy(busy), .msg_done(msg_done));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // uart_tx model: takes a strobe while ready, stays busy byte_cyc cycles.
  // In stub mode the first strobe is ignored and ready stays high 6 more cycles.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      uart_ready <= 1'b1; hold_cnt <= 0; busy_cnt <= 0;
    end else if (hold_cnt > 0) begin
      hold_cnt <= hold_cnt - 1;
      if (hold_cnt == 1) begin uart_ready <= 1'b0; busy_cnt <= byte_cyc; end
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) uart_ready <= 1'b1;
    end else if (uart_clock_enable && uart_ready) begin
      if (stub_mode && !stub_done) begin stub_done <= 1'b1; hold_cnt <= 6; end
      else begin uart_ready <= 1'b0; busy_cnt <= byte_cyc; end
    end
  end

  always @(negedge clock) begin
    if (uart_clock_enable === 1'b1) begin sq.push_back(uart_data); sc.push_back(cyc); end
    if (msg_done === 1'b1) dc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wr_addr = a[AW-1:0]; wr_data = d; wr_en = 1'b1;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic load_rand(input int len);
    for (int i = 0; i < len; i++) begin
      mem_model[i] = 8'($urandom);
      wr(i, mem_model[i]);
    end
  endtask

  task automatic send(input int len, input bit rep);
    msg_len = len[AW:0]; repeat_mode = rep; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin @(negedge clock); n++; end
    chk(tag, {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_dones(input int want, input int budget, output int got);
    int k = 0;
    got = 0;
    while (got < want && k < budget) begin
      @(negedge clock); k++;
      if (msg_done === 1'b1) got++;
    end
  endtask

  task automatic wait_strobes(input int want, input int budget);
    int ns = 0, k = 0;
    while (ns < want && k < budget) begin
      @(negedge clock); k++;
      if (uart_clock_enable === 1'b1) ns++;
    end
    chk("strobe_wait", ns, want);
  endtask

  // Expected stream: message bytes 0..len-1 repeated reps times.
  task automatic chk_seq(input string tag, input int base, input int len, input int reps);
    chk({tag, "_count"}, sq.size() - base, len * reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < len; i++)
        if (base + r * len + i < sq.size())
          chk({tag, "_byte"}, {24'b0, sq[base + r * len + i]}, {24'b0, mem_model[i]});
  endtask

  initial begin
    int base, bd, got, len;
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A};
    #2 reset = 1'b0;
    tick(3);
    chk("rst_ce", {31'b0, uart_clock_enable}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, msg_done}, 0);
    chk("rst_data", {24'b0, uart_data}, 0);
    reset = 1'b1;
    tick(2);

    // HELLO\r\n one-shot
    for (int i = 0; i < 7; i++) begin mem_model[i] = hello[i]; wr(i, hello[i]); end
    base = sq.size(); bd = dc.size();
    send(7, 1'b0);
    wait_dones(1, 3000, got);
    chk("hello_done", got, 1);
    wait_idle("hello_idle", 200);
    tick(3);
    chk_seq("hello", base, 7, 1);
    chk("hello_done_total", dc.size() - bd, 1);

    // Random one-shot
    byte_cyc = $urandom_range(3, 20);
    len = $urandom_range(1, DEPTH);
    load_rand(len);
    base = sq.size();
    send(len, 1'b0);
    wait_idle("rand_idle", 2000);
    tick(3);
    chk_seq("rand", base, len, 1);

    // Periodic, 2 bytes, gap 50, first message plus 3 repeats
    byte_cyc = 10; gap_cycles = 24'd50;
    load_rand(2);
    base = sq.size(); bd = dc.size();
    send(2, 1'b1);
    wait_dones(4, 5000, got);
    chk("rep_dones", got, 4);
    abort = 1'b1; @(negedge clock); abort = 1'b0;
    tick(3);
    chk("rep_busy", {31'b0, busy}, 0);
    chk_seq("rep", base, 2, 4);
    for (int k = 1; k < 4; k++) begin
      int diff;
      if (sc.size() > base + 2 * k && dc.size() > bd + k - 1) begin
        diff = sc[base + 2 * k] - dc[bd + k - 1];
        chk("rep_gap_ge50", {31'b0, diff >= 50}, 1);
      end
    end

    // Zero length start does nothing
    base = sq.size(); bd = dc.size();
    send(0, 1'b0);
    tick(2);
    chk("len0_busy", {31'b0, busy}, 0);
    tick(20);
    chk("len0_strobes", sq.size() - base, 0);
    chk("len0_done", dc.size() - bd, 0);

    // Full DEPTH message repeated twice, index wraps to 0
    byte_cyc = $urandom_range(2, 8);
    gap_cycles = GW'($urandom_range(0, 5));
    load_rand(DEPTH);
    base = sq.size();
    send(DEPTH, 1'b1);
    wait_dones(2, 4000, got);
    chk("depth_dones", got, 2);
    abort = 1'b1; @(negedge clock); abort = 1'b0;
    tick(3);
    chk("depth_busy", {31'b0, busy}, 0);
    chk_seq("depth", base, DEPTH, 2);

    // Abort during 3rd byte's WAIT_DONE, plus an ignored write
    byte_cyc = 40;
    load_rand(7);
    base = sq.size(); bd = dc.size();
    send(7, 1'b0);
    wait_strobes(3, 1000);
    tick(10);
    wr(0, ~mem_model[0]);
    abort = 1'b1; @(negedge clock); abort = 1'b0;
    wait_idle("abort_idle", 500);
    tick(5);
    chk_seq("abort", base, 3, 1);
    chk("abort_no_done", dc.size() - bd, 0);
    byte_cyc = 5;
    base = sq.size();
    send(1, 1'b0);
    wait_idle("memchk_idle", 200);
    tick(3);
    chk_seq("mem_unchanged", base, 1, 1);

    // uart_tx ignores the first strobe: one re-strobe with the same byte
    stub_mode = 1'b1;
    base = sq.size();
    send(2, 1'b0);
    wait_idle("stub_idle", 500);
    tick(3);
    chk("stub_count", sq.size() - base, 3);
    if (sq.size() >= base + 3) begin
      chk("stub_b0", {24'b0, sq[base]}, {24'b0, mem_model[0]});
      chk("stub_re", {24'b0, sq[base + 1]}, {24'b0, mem_model[0]});
      chk("stub_b1", {24'b0, sq[base + 2]}, {24'b0, mem_model[1]});
    end

    // Reset mid-byte while a strobe is high
    byte_cyc = 30;
    load_rand(7);
    send(7, 1'b0);
    wait_strobes(2, 500);
    #1 reset = 1'b0;
    #1;
    chk("mrst_ce", {31'b0, uart_clock_enable}, 0);
    chk("mrst_busy", {31'b0, busy}, 0);
    chk("mrst_done", {31'b0, msg_done}, 0);
    tick(3);
    reset = 1'b1;
    tick(2);
    byte_cyc = 6;
    base = sq.size();
    send(3, 1'b0);
    wait_idle("post_rst_idle", 500);
    tick(3);
    chk_seq("post_rst", base, 3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
